seg_disp_arbiter: RTL and testbench
===================================

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1000: minimum grant duration in clk cycles before non-alert preemption (>=1).
REQ-002 SHALL have parameter BLINK_HALF, default 25_000_000: alert blink half-period in clk cycles (>=1).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  3  request levels: bit0 menu, bit1 countdown, bit2 alert.
REQ-006 SHALL have port i_op_code  input  3  menu operation code (0=T, 1=A, 2=B, 3=C).
REQ-007 SHALL have port i_cnt_val  input  4  countdown digit value, 0..15.
REQ-008 SHALL have port o_grant  output  3  one-hot current owner; all zero when none.
REQ-009 SHALL have port o_en  output  1  display enable to the 7-seg driver.
REQ-010 SHALL have port o_disp_mode  output  1  0=operation glyph, 1=numeric.
REQ-011 SHALL have port o_op_code  output  3  glyph code to the driver.
REQ-012 SHALL have port o_digit_val  output  4  numeric value to the driver.

Function
REQ-013 SHALL implement FSM states IDLE, SERVE, GAP; all outputs registered.
REQ-014 SHALL use fixed priority alert > countdown > menu in every arbitration.
REQ-015 IDLE: o_en=0, o_grant=0; any i_req bit set -> SERVE next cycle, granting the highest-priority set bit and loading the hold counter with HOLD_CYCLES-1.
REQ-016 SERVE, menu owner: o_en=1, o_disp_mode=0, o_op_code=i_op_code, tracking input changes with 1-cycle latency.
REQ-017 SERVE, countdown owner: o_en=1, o_disp_mode=1, o_digit_val=i_cnt_val, tracking with 1-cycle latency.
REQ-018 SERVE, alert owner: o_disp_mode=0, o_op_code=3'd4 (E glyph); o_en=1 for BLINK_HALF cycles, then 0 for BLINK_HALF, repeating; blink counter restarts in the visible phase on each new alert grant.
REQ-019 SERVE: hold counter decrements each cycle and saturates at 0.
REQ-020 SERVE: owner's request deasserts -> GAP next cycle, regardless of hold counter.
REQ-021 SERVE: alert request asserts while a non-alert owner is served -> GAP next cycle, regardless of hold counter.
REQ-022 SERVE: countdown requests while menu is served -> GAP only once hold counter == 0.
REQ-023 GAP: exactly one cycle; o_en=0, o_grant=0, data outputs hold last values; then re-arbitrate as in IDLE (request -> SERVE, none -> IDLE).
REQ-024 Owner deasserts in the same cycle a higher request asserts -> single GAP, then highest request granted.
REQ-025 Lower-priority requests SHALL never preempt; they wait without loss while held high.
REQ-026 Once a grant is issued, o_grant SHALL change only via GAP (no direct owner-to-owner switch).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, o_grant=0, o_en=0, o_disp_mode=0, o_op_code=0, o_digit_val=0, hold and blink counters 0.
REQ-028 Reset asserted mid-SERVE SHALL drop the grant immediately; after release, arbitration restarts from IDLE on the next rising edge.

Structure
REQ-029 A shared package SHALL hold owner index constants (MENU=0, CNT=1, ALERT=2), the FSM state encoding, and the glyph code ALERT_GLYPH=3'd4.
REQ-030 The blink timer SHALL be a sub-module seg_blink_timer (restart input, BLINK_HALF parameter, phase output).

Verification (HOLD_CYCLES=4, BLINK_HALF=3)
REQ-031 i_req=001, i_op_code=2 -> IDLE, one cycle later o_grant=001, o_en=1, o_disp_mode=0, o_op_code=2.
REQ-032 menu served; i_req=011 at cycle 1 of grant -> menu held until hold counter 0 (4 grant cycles), one GAP cycle with o_en=0, then o_grant=010, o_digit_val=i_cnt_val.
REQ-033 countdown served, i_cnt_val=12; i_req bit2 rises -> next cycle GAP, then o_grant=100, o_op_code=4, o_en pattern 1,1,1,0,0,0,1...
REQ-034 alert served; i_req drops 111->011 -> one GAP, then countdown granted; blink restarts visible on a later alert.
REQ-035 owner drops and higher request rises in the same cycle -> exactly one GAP, then the higher requester granted.
REQ-036 rst_n pulsed low mid-SERVE -> all outputs 0 asynchronously; with i_req=010 held, o_grant=010 one cycle after release.

Source files
------------

// File: rtl/seg_disp_arbiter_pkg.sv
// rtl/seg_disp_arbiter_pkg.sv - shared constants for the 7-seg display arbiter
package seg_disp_arbiter_pkg;

    localparam int MENU  = 0;
    localparam int CNT   = 1;
    localparam int ALERT = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [2:0] ALERT_GLYPH = 3'd4;

    // Fixed priority: alert > countdown > menu, result is one-hot.
    function automatic logic [2:0] prio_pick(input logic [2:0] req);
        logic [2:0] pick;
        pick = '0;
        if (req[ALERT])
            pick[ALERT] = 1'b1;
        else if (req[CNT])
            pick[CNT] = 1'b1;
        else if (req[MENU])
            pick[MENU] = 1'b1;
        return pick;
    endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// rtl/seg_blink_timer.sv - alert blink generator, restartable in the visible phase
module seg_blink_timer #(
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] count;
    logic          vis;
    logic          wrap;

    // phase is the visibility the display should show after the coming edge,
    // so the owner can register it straight into its enable output.
    always_comb begin
        wrap  = (count == LAST);
        phase = restart ? 1'b1 : (wrap ? ~vis : vis);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            vis   <= 1'b0;
        end else begin
            if (restart || wrap)
                count <= '0;
            else
                count <= count + 1'b1;
            vis <= phase;
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - priority arbiter sharing one 7-seg display among three clients
module seg_disp_arbiter
    import seg_disp_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000,
    parameter int BLINK_HALF  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic [2:0] i_op_code,
    input  logic [3:0] i_cnt_val,
    output logic [2:0] o_grant,
    output logic       o_en,
    output logic       o_disp_mode,
    output logic [2:0] o_op_code,
    output logic [3:0] o_digit_val
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [2:0]    grant_d;
    logic          load;
    logic          leave;
    logic          restart;
    logic          blink;
    logic [HW-1:0] hold;

    // Every owner change passes through GAP; only IDLE/GAP may issue a grant.
    always_comb begin
        state_d = state;
        grant_d = o_grant;
        load    = 1'b0;
        leave   = 1'b0;
        case (state)
            ST_SERVE: begin
                leave = ((o_grant & i_req) == 3'b000)
                     || (i_req[ALERT] && !o_grant[ALERT])
                     || (o_grant[MENU] && i_req[CNT] && (hold == '0));
                if (leave) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                end
            end
            default: begin
                if (|i_req) begin
                    state_d = ST_SERVE;
                    grant_d = prio_pick(i_req);
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
        restart = load && grant_d[ALERT];
    end

    seg_blink_timer #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .phase  (blink)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            o_grant     <= '0;
            o_en        <= 1'b0;
            o_disp_mode <= 1'b0;
            o_op_code   <= '0;
            o_digit_val <= '0;
            hold        <= '0;
        end else begin
            state   <= state_d;
            o_grant <= grant_d;

            if (load)
                hold <= HOLD_LOAD;
            else if (state == ST_SERVE && hold != '0)
                hold <= hold - 1'b1;

            // Data outputs keep their last values whenever nobody is served.
            if (state_d != ST_SERVE) begin
                o_en <= 1'b0;
            end else if (grant_d[ALERT]) begin
                o_en        <= blink;
                o_disp_mode <= 1'b0;
                o_op_code   <= ALERT_GLYPH;
            end else if (grant_d[CNT]) begin
                o_en        <= 1'b1;
                o_disp_mode <= 1'b1;
                o_digit_val <= i_cnt_val;
            end else begin
                o_en        <= 1'b1;
                o_disp_mode <= 1'b0;
                o_op_code   <= i_op_code;
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - randomized scoreboard bench for seg_disp_arbiter
module tb_seg_disp_arbiter;

    localparam int HOLD = 4;
    localparam int BH   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req = '0;
    logic [2:0] op  = '0;
    logic [3:0] cnt = '0;
    logic [2:0] o_grant;
    logic       o_en;
    logic       o_disp_mode;
    logic [2:0] o_op_code;
    logic [3:0] o_digit_val;

    typedef struct packed {
        logic [2:0] grant;
        logic       en;
        logic       mode;
        logic [2:0] op;
        logic [3:0] digit;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: who owns the display, how long they have owned it.
    int   m_owner;
    bit   m_serving;
    int   m_served;
    exp_t m_out;

    seg_disp_arbiter #(
        .HOLD_CYCLES(HOLD),
        .BLINK_HALF (BH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (req),
        .i_op_code  (op),
        .i_cnt_val  (cnt),
        .o_grant    (o_grant),
        .o_en       (o_en),
        .o_disp_mode(o_disp_mode),
        .o_op_code  (o_op_code),
        .o_digit_val(o_digit_val)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string name, input exp_t e);
        exp_t a;
        a = '{grant: o_grant, en: o_en, mode: o_disp_mode, op: o_op_code, digit: o_digit_val};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: got grant=%b en=%b mode=%b op=%0d digit=%0d, expected grant=%b en=%b mode=%b op=%0d digit=%0d",
                     name, $time, a.grant, a.en, a.mode, a.op, a.digit,
                     e.grant, e.en, e.mode, e.op, e.digit);
        end
    endtask

    function automatic int highest(input logic [2:0] r);
        for (int i = 2; i >= 0; i--)
            if (r[i]) return i;
        return -1;
    endfunction

    function automatic void show_owner(input int owner, input int age);
        m_out.grant = 3'(1 << owner);
        if (owner == 2) begin
            m_out.mode = 1'b0;
            m_out.op   = 3'd4;
            m_out.en   = ((age / BH) % 2) == 0;
        end else if (owner == 1) begin
            m_out.en    = 1'b1;
            m_out.mode  = 1'b1;
            m_out.digit = cnt;
        end else begin
            m_out.en   = 1'b1;
            m_out.mode = 1'b0;
            m_out.op   = op;
        end
    endfunction

    function automatic void model_reset();
        m_owner   = -1;
        m_serving = 1'b0;
        m_served  = 0;
        m_out     = '0;
    endfunction

    // Predict the outputs after the coming rising edge from the current inputs.
    function automatic void model_step();
        bit leave;
        if (!m_serving) begin
            if (req != 3'b000) begin
                m_owner   = highest(req);
                m_serving = 1'b1;
                m_served  = 1;
                show_owner(m_owner, 0);
            end else begin
                m_out.grant = '0;
                m_out.en    = 1'b0;
            end
        end else begin
            leave = !req[m_owner]
                 || (req[2] && m_owner != 2)
                 || (m_owner == 0 && req[1] && m_served >= HOLD);
            if (leave) begin
                m_serving   = 1'b0;
                m_owner     = -1;
                m_out.grant = '0;
                m_out.en    = 1'b0;
            end else begin
                m_served++;
                show_owner(m_owner, m_served - 1);
            end
        end
    endfunction

    task automatic drive(input logic [2:0] r, input logic [2:0] o, input logic [3:0] c);
        req = r;
        op  = o;
        cnt = c;
        model_step();
        q.push_back(m_out);
    endtask

    task automatic cycle(input logic [2:0] r, input logic [2:0] o, input logic [3:0] c);
        @(negedge clk);
        drive(r, o, c);
    endtask

    task automatic pulse_reset(input logic [2:0] r, input logic [2:0] o, input logic [3:0] c);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out("async_reset", m_out);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(r, o, c);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0)
            check_out("scoreboard", q.pop_front());
    end

    initial begin
        logic [2:0] r;
        logic [2:0] o;
        logic [3:0] c;

        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_out("reset_state", m_out);
        rst_n = 1'b1;

        // Menu grant with op code tracking, then countdown waits out the hold.
        cycle(3'b000, 3'd2, 4'd0);
        cycle(3'b001, 3'd2, 4'd7);
        cycle(3'b011, 3'd3, 4'd7);
        cycle(3'b011, 3'd1, 4'd7);
        for (int i = 0; i < 6; i++) cycle(3'b011, 3'd0, 4'd12);
        // Alert preempts countdown; blink pattern runs over two periods.
        for (int i = 0; i < 14; i++) cycle(3'b111, 3'd1, 4'd12);
        // Alert drops, countdown returns, alert again restarts visible.
        for (int i = 0; i < 4; i++) cycle(3'b011, 3'd1, 4'd9);
        for (int i = 0; i < 5; i++) cycle(3'b111, 3'd1, 4'd9);
        for (int i = 0; i < 3; i++) cycle(3'b010, 3'd1, 4'd5);
        // Owner drops in the same cycle alert rises.
        for (int i = 0; i < 4; i++) cycle(3'b100, 3'd1, 4'd5);
        for (int i = 0; i < 3; i++) cycle(3'b010, 3'd1, 4'd3);
        pulse_reset(3'b010, 3'd0, 4'd6);
        for (int i = 0; i < 3; i++) cycle(3'b010, 3'd0, 4'd6);
        cycle(3'b000, 3'd0, 4'd6);
        cycle(3'b000, 3'd0, 4'd6);

        // Randomized sticky requests with occasional resets.
        r = '0;
        o = '0;
        c = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 3) == 0) o = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0)
                pulse_reset(r, o, c);
            else
                cycle(r, o, c);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
